// File: rtl/rom_burst_arbiter.sv
// rtl/rom_burst_arbiter.sv - two-client round-robin burst sequencer for the shared 8x4 lookup memory
// Define ROM_ARB_FIXED_PRI_EN for fixed priority (port 0 always wins a tie).
`timescale 1ns/1ps
module rom_burst_arbiter #(
    parameter int AW = 3,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [2:0]    len0,
    input  logic [2:0]    len1,
    output logic          gnt0,
    output logic          gnt1,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic [DW-1:0] data,
    output logic          valid0,
    output logic          valid1,
    output logic          last,
    output logic          busy
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t     r_state;
    logic       r_owner;
    logic [2:0] r_cnt;
    logic       w_win;

`ifdef ROM_ARB_FIXED_PRI_EN
    assign w_win = ~req0;
`else
    logic       r_ptr;
    // r_ptr holds the last-granted port; on a tie the other port wins.
    assign w_win = (req0 & req1) ? ~r_ptr : req1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_owner  <= 1'b0;
            r_cnt    <= 3'd0;
`ifndef ROM_ARB_FIXED_PRI_EN
            r_ptr    <= 1'b1;
`endif
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            rom_addr <= '0;
            data     <= '0;
            valid0   <= 1'b0;
            valid1   <= 1'b0;
            last     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    valid0 <= 1'b0;
                    valid1 <= 1'b0;
                    last   <= 1'b0;
                    gnt0   <= 1'b0;
                    gnt1   <= 1'b0;
                    if (req0 | req1) begin
                        r_owner  <= w_win;
                        rom_addr <= w_win ? addr1 : addr0;
                        r_cnt    <= w_win ? len1 : len0;
                        gnt0     <= ~w_win;
                        gnt1     <= w_win;
                        busy     <= 1'b1;
                        r_state  <= BURST;
`ifndef ROM_ARB_FIXED_PRI_EN
                        r_ptr    <= w_win;
`endif
                    end
                end
                BURST: begin
                    gnt0     <= 1'b0;
                    gnt1     <= 1'b0;
                    data     <= rom_data;
                    valid0   <= ~r_owner;
                    valid1   <= r_owner;
                    last     <= (r_cnt == 3'd0);
                    rom_addr <= rom_addr + 1'b1;
                    r_cnt    <= r_cnt - 1'b1;
                    if (r_cnt == 3'd0) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// tb/tb_rom_burst_arbiter.sv - self-checking bench for rom_burst_arbiter
`timescale 1ns/1ps
module tb_rom_burst_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [2:0] addr0 = '0, addr1 = '0, len0 = '0, len1 = '0;
    logic       gnt0, gnt1, valid0, valid1, last, busy;
    logic [2:0] rom_addr;
    logic [3:0] rom_data, data;

    always #5 clk = ~clk;

    // memory content mem[i] = 2i
    assign rom_data = {rom_addr, 1'b0};

    rom_burst_arbiter #(.AW(3), .DW(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1),
        .len0(len0), .len1(len1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .data(data), .valid0(valid0), .valid1(valid1),
        .last(last), .busy(busy)
    );

    typedef struct {
        logic       port;
        logic [3:0] data;
        logic       last;
    } sb_t;

    typedef struct {
        logic       port;
        logic [2:0] addr;
        logic [2:0] len;
        int         exp_busy;
    } vec_t;

    sb_t sb[$];
    int  gnt_log[$];
    int  checks = 0;
    int  failures = 0;
    sb_t mon_e;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input logic port, input logic [2:0] a, input logic [2:0] l, input int nw);
        for (int i = 0; i < nw; i++) begin
            sb_t e;
            logic [2:0] x;
            x = a + 3'(i);
            e.port = port;
            e.data = {x, 1'b0};
            e.last = (i == int'(l));
            sb.push_back(e);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_burst(input logic port, input logic [2:0] a, input logic [2:0] l, input int exp_busy);
        int n;
        if (port) begin addr1 = a; len1 = l; req1 = 1'b1; end
        else      begin addr0 = a; len0 = l; req0 = 1'b1; end
        sb_push(port, a, l, int'(l) + 1);
        tick();
        chk("gnt_own",   port ? int'(gnt1) : int'(gnt0), 1);
        chk("gnt_other", port ? int'(gnt0) : int'(gnt1), 0);
        chk("busy_start", int'(busy), 1);
        chk("rom_addr_start", int'(rom_addr), int'(a));
        if (port) begin req1 = 1'b0; addr1 = ~a; len1 = ~l; end
        else      begin req0 = 1'b0; addr0 = ~a; len0 = ~l; end
        n = 1;
        tick();
        chk("gnt_pulse", int'(gnt0 | gnt1), 0);
        if (busy) n++;
        while (busy && n < 20) begin
            tick();
            if (busy) n++;
        end
        chk("busy_cycles", n, exp_busy);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (gnt0) gnt_log.push_back(0);
            if (gnt1) gnt_log.push_back(1);
            if (valid0 | valid1) begin
                chk("one_hot_valid", int'(valid0 & valid1), 0);
                if (sb.size() == 0) begin
                    chk("unexpected_word", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("word_port", int'(valid1), int'(mon_e.port));
                    chk("word_data", int'(data), int'(mon_e.data));
                    chk("word_last", int'(last), int'(mon_e.last));
                end
            end else begin
                chk("last_without_valid", int'(last), 0);
            end
        end
    end

    vec_t vecs[6];
    int   fair_exp[4];

    initial begin
        vecs[0] = '{port: 1'b0, addr: 3'd1, len: 3'd2, exp_busy: 3};
        vecs[1] = '{port: 1'b1, addr: 3'd6, len: 3'd3, exp_busy: 4};
        vecs[2] = '{port: 1'b0, addr: 3'd0, len: 3'd7, exp_busy: 8};
        vecs[3] = '{port: 1'b1, addr: 3'd3, len: 3'd7, exp_busy: 8};
        vecs[4] = '{port: 1'b1, addr: 3'd7, len: 3'd0, exp_busy: 1};
        vecs[5] = '{port: 1'b0, addr: 3'd5, len: 3'd4, exp_busy: 5};
`ifdef ROM_ARB_FIXED_PRI_EN
        fair_exp = '{0, 0, 0, 0};
`else
        fair_exp = '{0, 1, 0, 1};
`endif

        tick();
        chk("reset_outputs", int'({gnt0, gnt1, valid0, valid1, last, busy}), 0);
        chk("reset_data", int'(data), 0);
        chk("reset_rom_addr", int'(rom_addr), 0);
        rst = 1'b0;
        tick();
        chk("idle_no_req_busy", int'(busy), 0);

        for (int v = 0; v < 6; v++)
            run_burst(vecs[v].port, vecs[v].addr, vecs[v].len, vecs[v].exp_busy);
        repeat (3) tick();

        // reset mid-burst after three words
        addr0 = 3'd2; len0 = 3'd7; req0 = 1'b1;
        sb_push(1'b0, 3'd2, 3'd7, 3);
        tick();
        chk("rst_test_gnt0", int'(gnt0), 1);
        req0 = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("reset_mid_outputs", int'({gnt0, gnt1, valid0, valid1, last, busy}), 0);
        chk("reset_mid_data_addr", int'({data, rom_addr}), 0);
        chk("reset_mid_sb_drained", sb.size(), 0);
        tick();
        tick();
        rst = 1'b0;
        run_burst(1'b0, 3'd3, 3'd1, 2);
        repeat (2) tick();

        // tie right after reset: port 0 first, port 1 one dead cycle later
        do_reset();
        addr0 = 3'd0; len0 = 3'd0; addr1 = 3'd7; len1 = 3'd0;
        req0 = 1'b1; req1 = 1'b1;
        sb_push(1'b0, 3'd0, 3'd0, 1);
        sb_push(1'b1, 3'd7, 3'd0, 1);
        tick();
        chk("tie_gnt0", int'(gnt0), 1);
        chk("tie_gnt1_low", int'(gnt1), 0);
        req0 = 1'b0;
        tick();
        chk("tie_word0_valid0", int'(valid0), 1);
        chk("tie_gnt1_not_yet", int'(gnt1), 0);
        tick();
        chk("tie_gnt1", int'(gnt1), 1);
        chk("tie_dead_cycle", int'(valid0 | valid1), 0);
        req1 = 1'b0;
        tick();
        chk("tie_word1_valid1", int'(valid1), 1);
        repeat (3) tick();

        // fairness with both requests held
        do_reset();
        gnt_log.delete();
        addr0 = 3'd1; len0 = 3'd0; addr1 = 3'd2; len1 = 3'd1;
        for (int i = 0; i < 4; i++) begin
            if (fair_exp[i] == 0) sb_push(1'b0, 3'd1, 3'd0, 1);
            else                  sb_push(1'b1, 3'd2, 3'd1, 2);
        end
        req0 = 1'b1; req1 = 1'b1;
        begin
            int n, cyc;
            n = 0; cyc = 0;
            while (n < 4 && cyc < 200) begin
                tick();
                cyc++;
                if (gnt0 | gnt1) n++;
            end
            req0 = 1'b0; req1 = 1'b0;
            chk("fair_grant_count", n, 4);
        end
        repeat (12) tick();
        chk("fair_log_size", gnt_log.size(), 4);
        if (gnt_log.size() >= 4)
            for (int i = 0; i < 4; i++)
                chk("fair_grant_order", gnt_log[i], fair_exp[i]);

        // withdrawn request during another burst
        gnt_log.delete();
        addr0 = 3'd0; len0 = 3'd3; req0 = 1'b1;
        sb_push(1'b0, 3'd0, 3'd3, 4);
        tick();
        chk("wd_gnt0", int'(gnt0), 1);
        req0 = 1'b0;
        tick();
        req1 = 1'b1; addr1 = 3'd4; len1 = 3'd2;
        tick();
        tick();
        req1 = 1'b0;
        repeat (8) tick();
        chk("wd_grant_log", gnt_log.size(), 1);
        chk("wd_idle", int'(busy), 0);
        chk("wd_no_gnt1", int'(gnt1), 0);

        repeat (2) tick();
        chk("sb_empty_at_end", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
